decode_sequencer: RTL and testbench

//  Parametrised multi-cycle decode sequencer between instruction fetch and the control ROM.
//  - Holds the instruction across multi-cycle phases and captures the second word of 32-bit instructions.
//  - Discards one or two words after a taken skip, and obeys pipeline stall and flush.
//  - The control ROM decodes inst_out/state_out and returns ctl_next_state, ctl_done and ctl_skip.

---
 rtl/decode_sequencer.sv | 153 +++++++++++++++
 tb/tb_decode_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/decode_sequencer.sv
// Multi-cycle decode sequencer between instruction fetch and the control ROM.
// Optional skip support is built when DECODE_SEQ_SKIP_EN is defined.
module decode_sequencer #(
  parameter int INST_W    = 16,
  parameter int STATE_W   = 2,
  parameter int MAX_STATE = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INST_W-1:0]  inst_in,
  input  logic               inst_valid,
  input  logic               is_32_bit_in,
  input  logic               stall_in,
  input  logic               flush_in,
  input  logic               branch_taken_in,
  input  logic [STATE_W-1:0] ctl_next_state,
  input  logic               ctl_done,
  input  logic               ctl_skip,
  output logic [INST_W-1:0]  inst_out,
  output logic [INST_W-1:0]  ext_out,
  output logic [STATE_W-1:0] state_out,
  output logic               decode_valid,
  output logic               fetch_en,
  output logic               busy,
  output logic               skipping,
  output logic               err
);

`ifdef DECODE_SEQ_SKIP_EN
  typedef enum logic [2:0] {DISPATCH, EXT, EXEC, SKIP1, SKIP2} phase_t;
`else
  typedef enum logic [1:0] {DISPATCH, EXT, EXEC} phase_t;
`endif

  localparam logic [STATE_W-1:0] MAX_S = STATE_W'(MAX_STATE);

  phase_t             phase;
  phase_t             exit_phase;
  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] exit_state;
  logic [INST_W-1:0]  inst_q;
  logic [INST_W-1:0]  ext_q;
  logic               err_q;
  logic               illegal;
  logic               done_eff;
  logic               base_valid;
  logic               base_fetch;

  assign illegal  = !ctl_done && ((ctl_next_state > MAX_S) || (ctl_next_state == '0));
  assign done_eff = ctl_done || illegal;

`ifndef DECODE_SEQ_SKIP_EN
  logic unused_skip;
  assign unused_skip = ctl_skip ^ branch_taken_in;
`endif

  // Where the sequencer goes after a phase that consults the control ROM.
  always_comb begin
    exit_phase = EXEC;
    exit_state = ctl_next_state;
    if (done_eff) begin
      exit_phase = DISPATCH;
      exit_state = '0;
`ifdef DECODE_SEQ_SKIP_EN
      if (ctl_skip && branch_taken_in) exit_phase = SKIP1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= DISPATCH;
      state  <= '0;
      inst_q <= '0;
      ext_q  <= '0;
      err_q  <= 1'b0;
    end else if (flush_in) begin
      phase <= DISPATCH;
      state <= '0;
    end else if (!stall_in) begin
      case (phase)
        DISPATCH: begin
          if (inst_valid) begin
            inst_q <= inst_in;
            ext_q  <= '0;
            if (is_32_bit_in) begin
              phase <= EXT;
            end else begin
              phase <= exit_phase;
              state <= exit_state;
              err_q <= err_q | illegal;
            end
          end
        end
        EXT: begin
          if (inst_valid) begin
            ext_q <= inst_in;
            phase <= exit_phase;
            state <= exit_state;
            err_q <= err_q | illegal;
          end
        end
        EXEC: begin
          phase <= exit_phase;
          state <= exit_state;
          err_q <= err_q | illegal;
        end
`ifdef DECODE_SEQ_SKIP_EN
        SKIP1: begin
          if (inst_valid) phase <= is_32_bit_in ? SKIP2 : DISPATCH;
        end
        SKIP2: begin
          if (inst_valid) phase <= DISPATCH;
        end
`endif
        default: phase <= DISPATCH;
      endcase
    end
  end

  // DISPATCH bypasses the fetched word so 16-bit single-phase ops add no latency.
  always_comb begin
    inst_out   = inst_q;
    base_valid = 1'b0;
    base_fetch = 1'b1;
    skipping   = 1'b0;
    case (phase)
      DISPATCH: begin
        inst_out   = inst_in;
        base_valid = inst_valid;
      end
      EXEC: begin
        base_valid = 1'b1;
        base_fetch = 1'b0;
      end
`ifdef DECODE_SEQ_SKIP_EN
      SKIP1, SKIP2: begin
        inst_out = '0;
        skipping = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign decode_valid = base_valid && !stall_in && !flush_in;
  assign fetch_en     = base_fetch && !(stall_in && !flush_in);
  assign busy         = (phase != DISPATCH);
  assign ext_out      = ext_q;
  assign state_out    = state;
  assign err          = err_q;

endmodule

// File: tb/tb_decode_sequencer.sv
// Table-driven bench for decode_sequencer with a queue-based scoreboard.
// Expectations follow the DECODE_SEQ_SKIP_EN setting of the build.
module tb_decode_sequencer;

`ifdef DECODE_SEQ_SKIP_EN
   localparam bit SK = 1'b1;
`else
   localparam bit SK = 1'b0;
`endif

   typedef struct packed {
      logic [15:0] inst;
      logic [15:0] ext;
      logic [1:0]  state;
      logic        dv;
      logic        fe;
      logic        busy;
      logic        skp;
      logic        err;
   } out_t;

   typedef struct {
      string       name;
      logic        rst, valid, is32, stall, flush, bt, skip, done;
      logic [1:0]  nxt;
      logic [15:0] inst;
      out_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] inst_in;
   logic        inst_valid, is_32_bit_in, stall_in, flush_in, branch_taken_in;
   logic [1:0]  ctl_next_state;
   logic        ctl_done, ctl_skip;
   logic [15:0] inst_out, ext_out;
   logic [1:0]  state_out;
   logic        decode_valid, fetch_en, busy, skipping, err;

   vec_t  vecs[$];
   out_t  expQ[$];
   string nameQ[$];
   int    applied = 0;
   int    miscompares = 0;

   always #5 clk = ~clk;

   decode_sequencer #(.INST_W(16), .STATE_W(2), .MAX_STATE(2)) dut (
      .clk(clk), .rst(rst), .inst_in(inst_in), .inst_valid(inst_valid),
      .is_32_bit_in(is_32_bit_in), .stall_in(stall_in), .flush_in(flush_in),
      .branch_taken_in(branch_taken_in), .ctl_next_state(ctl_next_state),
      .ctl_done(ctl_done), .ctl_skip(ctl_skip), .inst_out(inst_out),
      .ext_out(ext_out), .state_out(state_out), .decode_valid(decode_valid),
      .fetch_en(fetch_en), .busy(busy), .skipping(skipping), .err(err)
   );

   // Appends one cycle of stimulus with its expected outputs.
   task automatic add(input string n, input logic r, v, w32, st, fl, bt, sk, dn,
                      input logic [1:0] nx, input logic [15:0] in,
                      input logic [15:0] ei, ee, input logic [1:0] es,
                      input logic dv, fe, bz, skp, er);
      vec_t t;
      t.name = n; t.rst = r; t.valid = v; t.is32 = w32; t.stall = st; t.flush = fl;
      t.bt = bt; t.skip = sk; t.done = dn; t.nxt = nx; t.inst = in;
      t.exp = '{inst: ei, ext: ee, state: es, dv: dv, fe: fe, busy: bz, skp: skp, err: er};
      vecs.push_back(t);
   endtask

   task automatic applyStimulus(input vec_t t);
      rst = t.rst; inst_valid = t.valid; is_32_bit_in = t.is32; stall_in = t.stall;
      flush_in = t.flush; branch_taken_in = t.bt; ctl_skip = t.skip; ctl_done = t.done;
      ctl_next_state = t.nxt; inst_in = t.inst;
      expQ.push_back(t.exp);
      nameQ.push_back(t.name);
   endtask

   task automatic checkOutput();
      out_t  act, want;
      string n;
      act = '{inst: inst_out, ext: ext_out, state: state_out, dv: decode_valid,
              fe: fetch_en, busy: busy, skp: skipping, err: err};
      applied++;
      if (expQ.size() == 0) begin
         miscompares++;
         $display("[TB] FAIL scoreboard: got output with no expected entry");
         return;
      end
      want = expQ.pop_front();
      n = nameQ.pop_front();
      if (act !== want) begin
         miscompares++;
         $display("[TB] FAIL %s: got inst=%h ext=%h st=%0d dv=%b fe=%b busy=%b skp=%b err=%b, expected inst=%h ext=%h st=%0d dv=%b fe=%b busy=%b skp=%b err=%b",
                  n, act.inst, act.ext, act.state, act.dv, act.fe, act.busy, act.skp, act.err,
                  want.inst, want.ext, want.state, want.dv, want.fe, want.busy, want.skp, want.err);
      end
   endtask

   initial begin
      rst = 1'b1; inst_in = '0; inst_valid = 0; is_32_bit_in = 0; stall_in = 0;
      flush_in = 0; branch_taken_in = 0; ctl_next_state = '0; ctl_done = 0; ctl_skip = 0;

      //  name        rst v  32 st fl bt sk dn nx inst      e_inst    e_ext     st dv fe bz skp err
      add("reset0",    1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 0);
      add("reset1",    1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 0);
      add("add",       0, 1, 0, 0, 0, 0, 0, 1, 0, 16'h0C01, 16'h0C01, 16'h0000, 0, 1, 1, 0, 0, 0);
      add("idle0",     0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 0);
      add("lds_w1",    0, 1, 1, 0, 0, 0, 0, 0, 0, 16'h9100, 16'h9100, 16'h0000, 0, 1, 1, 0, 0, 0);
      add("lds_ext",   0, 1, 0, 0, 0, 0, 0, 1, 0, 16'h0100, 16'h9100, 16'h0000, 0, 0, 1, 1, 0, 0);
      add("lds_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0100, 0, 0, 1, 0, 0, 0);
      add("ph0",       0, 1, 0, 0, 0, 0, 0, 0, 1, 16'h9508, 16'h9508, 16'h0100, 0, 1, 1, 0, 0, 0);
      add("ph1",       0, 0, 0, 0, 0, 0, 0, 0, 2, 16'h0000, 16'h9508, 16'h0000, 1, 1, 0, 1, 0, 0);
      add("ph2",       0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h9508, 16'h0000, 2, 1, 0, 1, 0, 0);
      add("ph_back",   0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 0);
      // Skip over a 32-bit word pair, then the same sequence with the branch not taken.
      add("cpse_t",    0, 1, 0, 0, 0, 1, 1, 1, 0, 16'h1012, 16'h1012, 16'h0000, 0, 1, 1, 0, 0, 0);
      add("skip_w1",   0, 1, 1, 0, 0, 0, 0, 0, 0, 16'h940C, SK ? 16'h0000 : 16'h940C, 16'h0000, 0, !SK, 1, SK, SK, 0);
      add("skip_w2",   0, 1, 0, 0, 0, 0, 0, 1, 0, 16'h1234, SK ? 16'h0000 : 16'h940C, 16'h0000, 0, 0, 1, 1, SK, 0);
      add("skip_end",  0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, SK ? 16'h0000 : 16'h1234, 0, 0, 1, 0, 0, 0);
      add("cpse_nt",   0, 1, 0, 0, 0, 0, 1, 1, 0, 16'h1012, 16'h1012, SK ? 16'h0000 : 16'h1234, 0, 1, 1, 0, 0, 0);
      add("nt_w1",     0, 1, 1, 0, 0, 0, 0, 0, 0, 16'h940C, 16'h940C, 16'h0000, 0, 1, 1, 0, 0, 0);
      add("nt_w2",     0, 1, 0, 0, 0, 0, 0, 1, 0, 16'h1234, 16'h940C, 16'h0000, 0, 0, 1, 1, 0, 0);
      add("nt_end",    0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h1234, 0, 0, 1, 0, 0, 0);
      // Skip over a single 16-bit word with an idle gap while skipping.
      add("cpse_t16",  0, 1, 0, 0, 0, 1, 1, 1, 0, 16'h1012, 16'h1012, 16'h1234, 0, 1, 1, 0, 0, 0);
      add("skip_gap",  0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, SK, SK, 0);
      add("skip_w16",  0, 1, 0, 0, 0, 0, 0, 1, 0, 16'h0C01, SK ? 16'h0000 : 16'h0C01, 16'h0000, 0, !SK, 1, SK, SK, 0);
      add("skip16_end",0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 0);
      // Stall then flush+stall in EXEC phase 2.
      add("fl_ph0",    0, 1, 0, 0, 0, 0, 0, 0, 1, 16'h9508, 16'h9508, 16'h0000, 0, 1, 1, 0, 0, 0);
      add("fl_ph1",    0, 0, 0, 0, 0, 0, 0, 0, 2, 16'h0000, 16'h9508, 16'h0000, 1, 1, 0, 1, 0, 0);
      add("stall_ph2", 0, 0, 0, 1, 0, 0, 0, 1, 0, 16'h0000, 16'h9508, 16'h0000, 2, 0, 0, 1, 0, 0);
      add("flush_ph2", 0, 0, 0, 1, 1, 0, 0, 0, 1, 16'h0000, 16'h9508, 16'h0000, 2, 0, 0, 1, 0, 0);
      add("post_flush",0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 0);
      // Illegal next states raise a sticky err and act as done.
      add("ill_gt",    0, 1, 0, 0, 0, 0, 0, 0, 3, 16'h9508, 16'h9508, 16'h0000, 0, 1, 1, 0, 0, 0);
      add("err_set",   0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 1);
      add("ill_zero",  0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0C01, 16'h0C01, 16'h0000, 0, 1, 1, 0, 0, 1);
      add("flush_err", 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 1);
      add("ex_ph0",    0, 1, 0, 0, 0, 0, 0, 0, 1, 16'h9508, 16'h9508, 16'h0000, 0, 1, 1, 0, 0, 1);
      add("ex_ill",    0, 0, 0, 0, 0, 0, 0, 0, 3, 16'h0000, 16'h9508, 16'h0000, 1, 1, 0, 1, 0, 1);
      add("ex_back",   0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 1);
      add("rst_err1",  1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 1);
      add("rst_err0",  1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 0);

      @(posedge clk);
      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkOutput();
      end

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
